// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged FIFO.
// The optional FIFO_FWFT_EN macro, used in fifo_mem and fifo_flagged, selects first-word fall-through.
package fifo_pkg;

    localparam int DEF_M      = 8;
    localparam int DEF_N      = 10;
    localparam int DEF_AE_LVL = 2;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Wrap by compare so that depths which are not a power of two work.
    function automatic int ptr_inc(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// N x M storage with one synchronous write port and one read port.
// With FIFO_FWFT_EN defined, the read port is asynchronous. Otherwise it is registered and enabled by re.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int N  = DEF_N,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [M-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [M-1:0]  rdata
);

    logic [M-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef FIFO_FWFT_EN
    logic unused_re;
    assign unused_re = re;
    assign rdata     = mem[raddr];
`else
    logic [M-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, full/empty/almost flags and overflow/underflow pulses.
// Defining FIFO_FWFT_EN switches dout to first-word fall-through.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int M      = DEF_M,
    parameter int N      = DEF_N,
    parameter int AF_LVL = N - 2,
    parameter int AE_LVL = DEF_AE_LVL,
    parameter int CW     = cnt_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [M-1:0]  din,
    input  logic          rd,
    output logic [M-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = $clog2(N);
    localparam logic [CW-1:0] N_C  = CW'(N);
    localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LVL);

    logic [AW-1:0] wp_d, wp_q, rp_d, rp_q;
    logic [CW-1:0] count_d, count_q;
    logic          full_d, full_q, empty_d, empty_q;
    logic          af_d, af_q, ae_d, ae_q;
    logic          ovf_d, ovf_q, unf_d, unf_q;
    logic          rd_acc, wr_acc;
    logic [M-1:0]  mem_rdata;

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    always_comb begin
        rd_acc  = rd && (count_q != '0);
        wr_acc  = wr && ((count_q != N_C) || rd_acc);
        wp_d    = wr_acc ? AW'(ptr_inc(int'(wp_q), N)) : wp_q;
        rp_d    = rd_acc ? AW'(ptr_inc(int'(rp_q), N)) : rp_q;
        count_d = count_q;
        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
        full_d  = (count_d == N_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = wr && !wr_acc;
        unf_d   = rd && !rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_mem #(.M(M), .N(N), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wp_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rp_q),
        .rdata (mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    // Keep the last popped word so dout stays stable while the FIFO is empty.
    logic [M-1:0] last_d, last_q;

    always_comb begin
        last_d = last_q;
        if (rd_acc) last_d = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) last_q <= '0;
        else      last_q <= last_d;
    end

    assign dout = empty_q ? last_q : mem_rdata;
`else
    // The memory read register has no reset. Mask it until the first read after reset.
    logic dvld_d, dvld_q;

    always_comb begin
        dvld_d = dvld_q | rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) dvld_q <= 1'b0;
        else      dvld_q <= dvld_d;
    end

    assign dout = dvld_q ? mem_rdata : '0;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: doc/fifo_flagged.md
# fifo_flagged

Parametrised synchronous FIFO that succeeds the single-clock `fifo`. It adds status flags, an occupancy count, programmable almost-full and almost-empty thresholds, and overflow and underflow error pulses. Depth may be any value of 2 or more, not just a power of two. It sits between a producer and a consumer in one clock domain.

## Interface
Parameters:
- `M`, 8, data width in bits.
- `N`, 10, depth in entries; N ≥ 2.
- `AF_LVL`, N-2, almost_full asserts when count ≥ AF_LVL; 1 ≤ AF_LVL ≤ N.
- `AE_LVL`, 2, almost_empty asserts when count ≤ AE_LVL; 0 ≤ AE_LVL < N.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset; 0 = reset.
- `wr`  in  1  write request.
- `din`  in  M  write data.
- `rd`  in  1  read request.
- `dout`  out  M  read data.
- `full`  out  1  count == N.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LVL.
- `almost_empty`  out  1  count ≤ AE_LVL.
- `count`  out  CW  occupancy, where CW = $clog2(N+1).
- `overflow`  out  1  one-cycle pulse when a write was rejected.
- `underflow`  out  1  one-cycle pulse when a read was rejected.

## Operation
- Reset (`rst`=0 at a clock edge) sets the pointers to 0 and `count` to 0.
- Reset values: `dout`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored data.
- Write pointer `wp` and read pointer `rp` each count 0..N-1 and wrap from N-1 to 0 by compare. There is no power-of-two masking.
- Write is accepted when `wr` is 1 and either:
  - count < N, or
  - count == N and a read is accepted in the same cycle.
- Read is accepted when `rd` is 1 and count > 0. A write in the same cycle does not rescue a read from an empty FIFO.
- Count update per cycle:
  - +1 for an accepted write only.
  - −1 for an accepted read only.
  - unchanged when both or neither are accepted.
- Rejected write: data is discarded and `overflow` pulses for one cycle.
- Rejected read: `dout` holds its value and `underflow` pulses for one cycle.
- All flags and `count` are registered and reflect state after the edge.

## Timing
- Standard mode:
  - A read accepted at edge k presents mem[rp] on `dout` after edge k, i.e. one-cycle latency.
  - `dout` holds its value until the next accepted read.
- Write to flag latency: a write at edge k updates `empty`, `count` and the almost flags after edge k.
- Pulse latency: `overflow` and `underflow` are high for exactly the cycle following the rejected request.
- With full and rd+wr in the same cycle: both are accepted, `full` stays 1 and `count` stays N.
- With empty and rd+wr in the same cycle: the write is accepted, `underflow` pulses and `count` becomes 1.

## Configuration
- Macro: `FIFO_FWFT_EN`.
- When defined (first-word fall-through):
  - `dout` always shows the head entry whenever `empty`=0.
  - `rd` acts as an acknowledge that pops the head; the next entry appears after the edge.
  - A write into an empty FIFO is visible on `dout` in the cycle after the write edge.
  - `dout` shows the last popped value, or 0 after reset, while empty.
- When not defined: standard one-cycle registered read latency as specified above.
- Flag, count and error behaviour is identical in both modes.

## Structure
- Package `fifo_pkg` holds:
  - function `cnt_w(n)` returning $clog2(n+1);
  - a pointer-increment-with-wrap function;
  - default parameter constants.
- Sub-module `fifo_mem`: an N×M storage array with one synchronous write port and one read port.
  - The read port is registered in standard mode and asynchronous in FWFT mode.
  - Pointers, count, flags and error logic stay in `fifo_flagged`.

## Test plan
All scenarios use N=10, M=8, AF_LVL=8, AE_LVL=2.
1. Reset, then `rd`=1 for one cycle on the empty FIFO -> `underflow` high for one cycle; `count`=0; `dout`=0.
2. Six single writes 0x11..0x16, then six reads -> `dout` is 0x11..0x16 in order; `count` goes 6 -> 0; `almost_empty` deasserts at count 3 and reasserts at count 2.
3. Twelve writes 0x20..0x2B with no reads -> `full`=1 at count 10; `almost_full` from count 8; two `overflow` pulses; ten reads return 0x20..0x29, covering pointer wrap.
4. Fill to 10, then rd+wr of 0x99 in the same cycle -> `count` stays 10, no `overflow`; the tenth subsequent read returns 0x99.
5. Empty FIFO, rd+wr of 0x55 in the same cycle -> `underflow` pulses; `count`=1; the next read returns 0x55.
6. With 5 entries stored, hold `rst`=0 for one edge -> `count`=0, `empty`=1, `dout`=0; a following write then read returns the new data. Repeat scenarios 2 and 4 with `FIFO_FWFT_EN` defined and check the head is visible without a read.
